// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: streams a row-major frame buffer out as byte-wide AXI-Stream beats,
// using a 2-entry skid FIFO with a bypass so the first beat leaves two cycles after start.
module pixel_stream_tx #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 8,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        axi_data_out,
  output logic [3:0]        axi_keep,
  output logic              axi_valid,
  output logic              axi_last,
  input  logic              axi_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] pix;
  logic [7:0] fifo [2];
  logic [1:0] occ, total;
  logic pend, wp, rp, pop, push, fpop, accept;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? RUN
             : (state == RUN && mem_ren && mem_raddr == LAST) ? DRAIN
             : (state == DRAIN && pop && axi_last) ? IDLE
             : state;
  // Data returning this cycle bypasses the FIFO when it is empty; total counts held plus in-flight pixels.
  always_comb begin
    total = occ + {1'b0, pend};
    axi_valid = occ != 2'd0 || pend;
    axi_data_out = occ != 2'd0 ? fifo[rp] : pend ? mem_rdata : 8'h00;
    axi_last = axi_valid && pix == LAST;
    axi_keep = 4'b0001;
    pop = axi_valid && axi_ready;
    mem_ren = state == RUN && (total <= 2'd1 || (total == 2'd2 && pop));
    busy = state != IDLE;
    accept = state == IDLE && start && !done;
    push = pend && !(pop && occ == 2'd0);
    fpop = pop && occ != 2'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      mem_raddr <= '0;
      pix <= '0;
      occ <= 2'd0;
      wp <= 1'b0;
      rp <= 1'b0;
      done <= 1'b0;
    end else begin
      pend <= mem_ren;
      if (mem_ren) mem_raddr <= mem_raddr == LAST ? '0 : mem_raddr + 1'b1;
      if (pop) pix <= pix == LAST ? '0 : pix + 1'b1;
      if (push) wp <= ~wp;
      if (fpop) rp <= ~rp;
      occ <= occ + 2'(push) - 2'(fpop);
      done <= pop && axi_last;
    end
  always_ff @(posedge clk)
    if (push) fifo[wp] <= mem_rdata;
endmodule
